// File: rtl/mips_pkg.sv
// Shared MIPS-I subset definitions: opcodes, function codes, ALU operations, reset vector.
package mips_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;

  localparam logic [XLEN-1:0] RESET_VECTOR_DEF = 32'hBFC0_0000;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
    ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI
  } alu_op_e;

endpackage

// File: rtl/mips_regfile.sv
// 32x32 general-purpose register file: two combinational read ports, one write port, $0 hardwired to zero.
module mips_regfile
  import mips_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              we_i,
  input  logic [REG_AW-1:0] waddr_i,
  input  logic [XLEN-1:0]   wdata_i,
  input  logic [REG_AW-1:0] raddr_a_i,
  input  logic [REG_AW-1:0] raddr_b_i,
  output logic [XLEN-1:0]   rdata_a_o,
  output logic [XLEN-1:0]   rdata_b_o,
  output logic [XLEN-1:0]   v0_o
);

  logic [XLEN-1:0] regs_q [32];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      regs_q <= '{default: '0};
    end else if (we_i && (waddr_i != '0)) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o = (raddr_a_i == '0) ? '0 : regs_q[raddr_a_i];
  assign rdata_b_o = (raddr_b_i == '0) ? '0 : regs_q[raddr_b_i];
  assign v0_o      = regs_q[2];

endmodule

// File: rtl/mips_cpu_harvard.sv
// Single-cycle MIPS-I subset CPU with Harvard memory ports, branch delay slot and halt-on-jump-to-zero.
module mips_cpu_harvard
  import mips_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_VECTOR = RESET_VECTOR_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clk_enable,
  output logic            active,
  output logic [XLEN-1:0] register_v0,
  output logic [XLEN-1:0] instr_address,
  input  logic [XLEN-1:0] instr_readdata,
  output logic [XLEN-1:0] data_address,
  output logic            data_write,
  output logic            data_read,
  output logic [XLEN-1:0] data_writedata,
  input  logic [XLEN-1:0] data_readdata
);

  logic [XLEN-1:0] pc_q, pc_d, pend_target_q, pend_target_d;
  logic            active_q, active_d, pend_valid_q, pend_valid_d;

  logic [5:0]        opcode, funct;
  logic [REG_AW-1:0] rs, rt, rd, shamt;
  logic [15:0]       imm;
  logic [25:0]       idx;
  logic [XLEN-1:0]   imm_sext, imm_zext, rs_val, rt_val, opb, alu_res, wdata;
  logic [XLEN-1:0]   pc_plus4, pc_plus8, br_target;
  logic [REG_AW-1:0] dest;
  alu_op_e           alu_op;
  logic              use_imm, zext, reg_we, is_lw, is_sw, br_taken, link, exec;

  assign opcode   = instr_readdata[31:26];
  assign rs       = instr_readdata[25:21];
  assign rt       = instr_readdata[20:16];
  assign rd       = instr_readdata[15:11];
  assign shamt    = instr_readdata[10:6];
  assign funct    = instr_readdata[5:0];
  assign imm      = instr_readdata[15:0];
  assign idx      = instr_readdata[25:0];
  assign imm_sext = {{16{imm[15]}}, imm};
  assign imm_zext = {16'h0, imm};
  assign pc_plus4 = pc_q + 32'd4;
  assign pc_plus8 = pc_q + 32'd8;

  // Decode: unknown opcodes/functs fall through the defaults and behave as NOP.
  always_comb begin
    alu_op    = ALU_ADD;
    use_imm   = 1'b0;
    zext      = 1'b0;
    reg_we    = 1'b0;
    dest      = rd;
    is_lw     = 1'b0;
    is_sw     = 1'b0;
    br_taken  = 1'b0;
    br_target = '0;
    link      = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        reg_we = 1'b1;
        case (funct)
          FN_SLL:  alu_op = ALU_SLL;
          FN_SRL:  alu_op = ALU_SRL;
          FN_SRA:  alu_op = ALU_SRA;
          FN_ADDU: alu_op = ALU_ADD;
          FN_SUBU: alu_op = ALU_SUB;
          FN_AND:  alu_op = ALU_AND;
          FN_OR:   alu_op = ALU_OR;
          FN_XOR:  alu_op = ALU_XOR;
          FN_SLT:  alu_op = ALU_SLT;
          FN_SLTU: alu_op = ALU_SLTU;
          FN_JR: begin
            reg_we    = 1'b0;
            br_taken  = 1'b1;
            br_target = rs_val;
          end
          default: reg_we = 1'b0;
        endcase
      end
      OP_J, OP_JAL: begin
        br_taken  = 1'b1;
        br_target = {pc_plus4[31:28], idx, 2'b00};
        link      = (opcode == OP_JAL);
        reg_we    = (opcode == OP_JAL);
        dest      = 5'd31;
      end
      OP_BEQ, OP_BNE: begin
        br_taken  = (rs_val == rt_val) ^ (opcode == OP_BNE);
        br_target = pc_plus4 + (imm_sext << 2);
      end
      OP_ADDIU: begin alu_op = ALU_ADD;  use_imm = 1'b1; reg_we = 1'b1; dest = rt; end
      OP_SLTI:  begin alu_op = ALU_SLT;  use_imm = 1'b1; reg_we = 1'b1; dest = rt; end
      OP_SLTIU: begin alu_op = ALU_SLTU; use_imm = 1'b1; reg_we = 1'b1; dest = rt; end
      OP_ANDI:  begin alu_op = ALU_AND;  use_imm = 1'b1; zext = 1'b1; reg_we = 1'b1; dest = rt; end
      OP_ORI:   begin alu_op = ALU_OR;   use_imm = 1'b1; zext = 1'b1; reg_we = 1'b1; dest = rt; end
      OP_XORI:  begin alu_op = ALU_XOR;  use_imm = 1'b1; zext = 1'b1; reg_we = 1'b1; dest = rt; end
      OP_LUI:   begin alu_op = ALU_LUI;  reg_we = 1'b1; dest = rt; end
      OP_LW:    begin use_imm = 1'b1; is_lw = 1'b1; reg_we = 1'b1; dest = rt; end
      OP_SW:    begin use_imm = 1'b1; is_sw = 1'b1; end
      default: ;
    endcase
  end

  assign opb = use_imm ? (zext ? imm_zext : imm_sext) : rt_val;

  always_comb begin
    alu_res = rs_val + opb;
    case (alu_op)
      ALU_SUB:  alu_res = rs_val - opb;
      ALU_AND:  alu_res = rs_val & opb;
      ALU_OR:   alu_res = rs_val | opb;
      ALU_XOR:  alu_res = rs_val ^ opb;
      ALU_SLT:  alu_res = {31'b0, $signed(rs_val) < $signed(opb)};
      ALU_SLTU: alu_res = {31'b0, rs_val < opb};
      ALU_SLL:  alu_res = rt_val << shamt;
      ALU_SRL:  alu_res = rt_val >> shamt;
      ALU_SRA:  alu_res = $signed(rt_val) >>> shamt;
      ALU_LUI:  alu_res = {imm, 16'h0};
      default:  ;
    endcase
  end

  assign exec  = clk_enable && active_q;
  assign wdata = link ? pc_plus8 : (is_lw ? data_readdata : alu_res);

  mips_regfile u_regfile (
    .clk_i     (clk),
    .rst_ni    (reset),
    .we_i      (exec && reg_we),
    .waddr_i   (dest),
    .wdata_i   (wdata),
    .raddr_a_i (rs),
    .raddr_b_i (rt),
    .rdata_a_o (rs_val),
    .rdata_b_o (rt_val),
    .v0_o      (register_v0)
  );

  // Taken branches arm a one-shot redirect applied after the delay slot; PC 0 is the halt point.
  always_comb begin
    pc_d          = pc_q;
    active_d      = active_q;
    pend_valid_d  = pend_valid_q;
    pend_target_d = pend_target_q;
    if (exec) begin
      if (pc_q == '0) begin
        active_d     = 1'b0;
        pend_valid_d = 1'b0;
      end else begin
        pc_d          = pend_valid_q ? pend_target_q : pc_plus4;
        pend_valid_d  = br_taken;
        pend_target_d = br_target;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q          <= RESET_VECTOR;
      active_q      <= 1'b1;
      pend_valid_q  <= 1'b0;
      pend_target_q <= '0;
    end else begin
      pc_q          <= pc_d;
      active_q      <= active_d;
      pend_valid_q  <= pend_valid_d;
      pend_target_q <= pend_target_d;
    end
  end

  assign active         = active_q;
  assign instr_address  = pc_q;
  assign data_address   = alu_res;
  assign data_writedata = rt_val;
  assign data_write     = reset && exec && is_sw;
  assign data_read      = reset && exec && is_lw;

endmodule

// File: tb/tb_mips_cpu_harvard.sv
// Directed program bench for mips_cpu_harvard with store and result scoreboards.
module tb_mips_cpu_harvard;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } st_t;

  logic        clk, reset, clk_enable, active, data_write, data_read;
  logic [31:0] register_v0, instr_address, instr_readdata;
  logic [31:0] data_address, data_writedata, data_readdata;

  logic [31:0] boot [64];
  logic [31:0] low  [16];
  logic [31:0] dmem [64];
  st_t         st_q [$];
  logic [31:0] v0_q [$];
  int          n_cmp = 0;
  int          n_err = 0;

  mips_cpu_harvard dut (
    .clk            (clk),
    .reset          (reset),
    .clk_enable     (clk_enable),
    .active         (active),
    .register_v0    (register_v0),
    .instr_address  (instr_address),
    .instr_readdata (instr_readdata),
    .data_address   (data_address),
    .data_write     (data_write),
    .data_read      (data_read),
    .data_writedata (data_writedata),
    .data_readdata  (data_readdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign instr_readdata = (instr_address[31:8] == 24'hBFC000) ? boot[instr_address[7:2]] :
                          (instr_address[31:6] == 26'h0)      ? low[instr_address[5:2]]   : 32'h0;
  assign data_readdata  = dmem[data_address[7:2]];

  always @(posedge clk) begin
    if (data_write) dmem[data_address[7:2]] <= data_writedata;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // Every store strobe must match the oldest expected store.
  always @(negedge clk) begin
    if (data_write === 1'b1) begin
      if (st_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $error("FAIL store_unexpected observed=%08h/%08h expected=none", data_address, data_writedata);
      end else begin
        st_t e;
        e = st_q.pop_front();
        check("store_addr", data_address, e.addr);
        check("store_data", data_writedata, e.data);
      end
    end
  end

  function automatic logic [31:0] ri(input logic [5:0] fn, input int rs, input int rt, input int rd, input int sh);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'(sh), fn};
  endfunction

  function automatic logic [31:0] ii(input logic [5:0] op, input int rs, input int rt, input logic [15:0] imm);
    return {op, 5'(rs), 5'(rt), imm};
  endfunction

  function automatic logic [31:0] jj(input logic [5:0] op, input logic [31:0] target);
    return {op, target[27:2]};
  endfunction

  task automatic clear_prog();
    for (int i = 0; i < 64; i++) boot[i] = 32'h0;
    for (int i = 0; i < 16; i++) low[i] = 32'h0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clk_enable = 1'b1;
    reset = 1'b0;
    repeat (2) step();
    @(negedge clk);
    reset = 1'b1;
    #1;
  endtask

  task automatic run_to_halt();
    for (int i = 0; i < 300 && active; i++) step();
    check("halt_reached", {31'b0, active}, 32'h0);
  endtask

  task automatic check_v0(input string tag);
    check(tag, register_v0, v0_q.pop_front());
  endtask

  // BNE not taken, BEQ taken over one instruction, delay slot increments v0.
  task automatic load_branch_prog();
    clear_prog();
    boot[0] = ii(6'h05, 2, 0, 16'd5);
    boot[1] = ii(6'h04, 0, 0, 16'd2);
    boot[2] = ii(6'h09, 2, 2, 16'd1);
    boot[3] = ii(6'h09, 2, 2, 16'd16);
    boot[4] = ri(6'h08, 0, 0, 0, 0);
    v0_q.push_back(32'h1);
  endtask

  int          alu_regs [15] = '{7, 8, 9, 10, 11, 12, 13, 14, 15, 16, 17, 0, 18, 19, 20};
  logic [31:0] alu_vals [15] = '{32'h1, 32'h0, 32'hFFFFFFFC, 32'hF, 32'h30, 32'hB, 32'hFFFF0007,
                                 32'hF0, 32'h1, 32'h0, 32'hFFFFFFFB, 32'h0, 32'h0,
                                 32'hFFFFFFFB, 32'hFFFFFFFB};

  initial begin
    reset = 1'b0;
    clk_enable = 1'b0;

    // Strobes stay low while reset is held, even with a memory op at the reset vector.
    clear_prog();
    boot[0] = ii(6'h2B, 0, 0, 16'h40);
    clk_enable = 1'b1;
    step();
    check("rst_data_write", {31'b0, data_write}, 32'h0);
    boot[0] = ii(6'h23, 0, 2, 16'h40);
    #1;
    check("rst_data_read", {31'b0, data_read}, 32'h0);

    // Program 1: ADDIU then JR $0 with NOP delay slot; halt one edge after reaching 0.
    clear_prog();
    boot[0] = ii(6'h09, 0, 2, 16'd5);
    boot[1] = ri(6'h08, 0, 0, 0, 0);
    check("rst_pc", instr_address, 32'hBFC00000);
    check("rst_active", {31'b0, active}, 32'h1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rel_pc", instr_address, 32'hBFC00000);
    check("rel_v0", register_v0, 32'h0);
    for (int i = 0; i < 10 && instr_address != 32'h0; i++) step();
    check("p1_reach_zero", instr_address, 32'h0);
    check("p1_active_at_zero", {31'b0, active}, 32'h1);
    step();
    check("p1_active_fell", {31'b0, active}, 32'h0);
    check("p1_v0", register_v0, 32'h5);
    repeat (3) step();
    check("p1_pc_hold", instr_address, 32'h0);
    check("p1_v0_hold", register_v0, 32'h5);

    // Program 2: build constant, store then load it back into v0.
    clear_prog();
    boot[0] = ii(6'h0F, 0, 3, 16'h1234);
    boot[1] = ii(6'h0D, 3, 3, 16'h5678);
    boot[2] = ii(6'h09, 0, 4, 16'h0010);
    boot[3] = ii(6'h2B, 4, 3, 16'h0);
    boot[4] = ii(6'h23, 4, 2, 16'h0);
    boot[5] = ri(6'h08, 0, 0, 0, 0);
    st_q.push_back('{32'h10, 32'h12345678});
    v0_q.push_back(32'h12345678);
    do_reset();
    run_to_halt();
    check_v0("p2_v0");

    // Program 3: branches and delay slot.
    load_branch_prog();
    do_reset();
    run_to_halt();
    check_v0("p3_v0");

    // Program 4: JAL links PC+8 into $31; target copies it to v0.
    clear_prog();
    boot[1]  = jj(6'h03, 32'hBFC00020);
    boot[8]  = ri(6'h21, 31, 0, 2, 0);
    boot[9]  = ri(6'h08, 0, 0, 0, 0);
    v0_q.push_back(32'hBFC0000C);
    do_reset();
    run_to_halt();
    check_v0("p4_v0");

    // Program 5: freeze for 5 cycles while a branch redirect is pending.
    load_branch_prog();
    do_reset();
    repeat (2) step();
    clk_enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("frz_pc", instr_address, 32'hBFC00008);
      check("frz_v0", register_v0, 32'h0);
    end
    clk_enable = 1'b1;
    step();
    check("frz_resume_v0", register_v0, 32'h1);
    check("frz_resume_pc", instr_address, 32'hBFC00010);
    run_to_halt();
    check_v0("p5_v0");

    // Program 6: reset asserted while a branch is pending discards it.
    load_branch_prog();
    do_reset();
    repeat (2) step();
    reset = 1'b0;
    #1;
    check("mid_rst_pc", instr_address, 32'hBFC00000);
    check("mid_rst_active", {31'b0, active}, 32'h1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("mid_rst_pc2", instr_address, 32'hBFC00000);
    run_to_halt();
    check_v0("p6_v0");

    // Program 7: ALU coverage via stores; the store at address 0 runs once at halt.
    clear_prog();
    boot[0]  = ii(6'h09, 0, 5, 16'hFFF8);
    boot[1]  = ii(6'h09, 0, 6, 16'd3);
    boot[2]  = ri(6'h2A, 5, 6, 7, 0);
    boot[3]  = ri(6'h2B, 5, 6, 8, 0);
    boot[4]  = ri(6'h03, 0, 5, 9, 1);
    boot[5]  = ri(6'h02, 0, 5, 10, 28);
    boot[6]  = ri(6'h00, 0, 6, 11, 4);
    boot[7]  = ri(6'h23, 6, 5, 12, 0);
    boot[8]  = ii(6'h0E, 5, 13, 16'hFFFF);
    boot[9]  = ii(6'h0C, 5, 14, 16'h00F0);
    boot[10] = ii(6'h0B, 6, 15, 16'hFFFF);
    boot[11] = ii(6'h0A, 5, 16, 16'hFFF7);
    boot[12] = ri(6'h25, 5, 6, 17, 0);
    boot[13] = ii(6'h09, 0, 0, 16'd7);
    boot[14] = ri(6'h24, 5, 6, 18, 0);
    boot[15] = ri(6'h26, 5, 6, 19, 0);
    boot[16] = ri(6'h21, 5, 6, 20, 0);
    for (int k = 0; k < 15; k++) begin
      boot[17 + k] = ii(6'h2B, 0, alu_regs[k], 16'(32'h20 + 4 * k));
      st_q.push_back('{32'h20 + 32'(4 * k), alu_vals[k]});
    end
    boot[32] = ri(6'h08, 0, 0, 0, 0);
    low[0]   = ii(6'h2B, 0, 6, 16'h007C);
    st_q.push_back('{32'h7C, 32'h3});
    v0_q.push_back(32'h0);
    do_reset();
    run_to_halt();
    repeat (3) step();
    check_v0("p7_v0");
    check("store_q_drained", 32'(st_q.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
